dac8531_update_arbiter: RTL and testbench
=========================================

// Module: dac8531_update_arbiter
// PURPOSE
//  Shares the DAC8531 serial writer (TR/DATA in, OVER out) between N_REQ calibration requesters.
//  Round-robin arbitration, latches the granted 16-bit code, runs the TR/OVER handshake,
//  enforces a minimum idle gap between DAC frames, and flags a hung writer via timeout.
//  Sits between the frequency-calibration control loops and the DAC writer instance.
// PARAMETERS
//  N_REQ    4     number of requesters, 2..8
//  MIN_GAP  16    idle cycles after each completed frame before the next grant, >=1
//  TIMEOUT  256   max cycles per handshake phase (accept, done) before abort, >=64
// PORTS
//  CLK        in   1           system clock, all logic on rising edge
//  RESET_N    in   1           asynchronous active-low reset
//  REQ        in   N_REQ       level request per requester; hold until ACK
//  CODE       in   16*N_REQ    requester i code on CODE[16*i+15:16*i]; stable while REQ
//  ACK        out  N_REQ       one-cycle pulse to the granted requester on completion
//  BUSY       out  1           high from grant until HOLD phase ends
//  DAC_TR     out  1           trigger to writer
//  DAC_DATA   out  24          frame to writer: {8'h00, code}
//  DAC_OVER   in   1           writer idle/done flag: high = idle, low = frame in progress
//  LAST_CODE  out  16          code of last successfully written frame
//  ERR        out  1           sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, ACK=0, BUSY=0, DAC_TR=0, DAC_DATA=0,
//   LAST_CODE=0, ERR=0, rr pointer=0, counters=0.
//  States:
//   IDLE   : if |REQ and DAC_OVER=1 -> pick first set REQ scanning up from rr pointer
//            (wrap at N_REQ); latch index and code into DAC_DATA; BUSY<=1; ->LAUNCH.
//            If DAC_OVER=0, wait in IDLE (writer still draining).
//   LAUNCH : DAC_TR=1 held every cycle until DAC_OVER sampled low -> DAC_TR<=0, ->DONE.
//            Counter reaching TIMEOUT -> DAC_TR<=0, ERR<=1, ->HOLD (no ACK).
//   DONE   : wait DAC_OVER sampled high -> ACK[idx] pulse 1 cycle, LAST_CODE<=code,
//            rr pointer<=(idx+1) mod N_REQ, ->HOLD. TIMEOUT -> ERR<=1, ->HOLD (no ACK).
//   HOLD   : count MIN_GAP cycles, BUSY stays 1; then BUSY<=0, ->IDLE.
//  Latency: grant is registered one cycle after REQ is seen in IDLE; ACK arrives one cycle
//   after the DAC_OVER rising edge.
//  Timeout counter resets on every state entry; per-phase, not cumulative.
//  Aborted request keeps its REQ level and is retried on a later grant; the rr pointer is not
//   advanced on abort, so the same requester is re-picked first.
//  REQ dropped after grant: frame still completes; ACK still pulses (ignored by requester).
//  REQ dropped before grant: withdrawn, no effect. CODE changes after grant are ignored.
//  Simultaneous REQs: exactly one grant per frame; no requester starves (<=N_REQ frames wait).
//  DAC_DATA[23:16] always 0 (normal power mode). DAC_DATA holds value between frames.
//  At most one ACK bit high in any cycle.
// CONFIGURATION
//  SKIP_DUP_EN defined: in IDLE, if the selected code equals LAST_CODE and at least one
//   frame has completed since reset, skip LAUNCH/DONE/HOLD: pulse ACK[idx] next cycle,
//   advance rr pointer, stay IDLE, no DAC_TR. A first frame after reset is never skipped.
//  SKIP_DUP_EN undefined: every grant produces a full DAC frame.
// TESTING
//  1 Single REQ[0], CODE0=16'h1234, writer model -> one TR, DAC_DATA=24'h001234,
//    ACK[0] 1 cycle after OVER rises, LAST_CODE=16'h1234, BUSY low after 16-cycle gap.
//  2 REQ=4'b1111 held, distinct codes -> grants in order 0,1,2,3,0; every frame gap >=16 cycles.
//  3 Writer model never drops OVER -> TR held 256 cycles, ERR=1, no ACK; REQ still
//    high -> retried to the same requester; ERR stays 1 after later success.
//  4 Reset asserted mid-DONE -> all outputs to reset values immediately; after release,
//    pending REQ is served from requester 0.
//  5 SKIP_DUP_EN: write 16'h00FF, then same requester again with 16'h00FF -> second ACK
//    with no TR; 16'h0100 -> full frame. Undefined: both frames issued.
//  6 REQ[2] pulsed 1 cycle while BUSY with another frame -> never granted, no ACK[2].

Source files
------------

// File: rtl/dac8531_update_arbiter.sv
// Purpose : round-robin arbiter sharing one DAC8531 serial writer among N_REQ requesters.
// Latency : grant 1 cycle after REQ is seen in IDLE; ACK 1 cycle after DAC_OVER rises.
// Backpres: REQ is a level held until ACK; grants wait for DAC_OVER=1 and a MIN_GAP idle gap.
//
// Ports:
//   CLK, RESET_N        clock and asynchronous active-low reset
//   REQ  [N_REQ]        level request per requester, held until its ACK
//   CODE [16*N_REQ]     requester i code on CODE[16*i+15:16*i]
//   ACK  [N_REQ]        one-cycle completion pulse to the granted requester
//   BUSY                high from grant until the post-frame gap ends
//   DAC_TR              trigger to the writer, held until DAC_OVER goes low
//   DAC_DATA [24]       {8'h00, code}; holds its value between frames
//   DAC_OVER            writer flag: 1 = idle, 0 = frame in progress
//   LAST_CODE [16]      code of the last successfully written frame
//   ERR                 sticky handshake timeout flag, cleared only by reset
//
// Build option: define SKIP_DUP_EN to acknowledge a request whose code equals
// LAST_CODE without issuing a frame (never before the first completed frame).
module dac8531_update_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MIN_GAP = 16,
    parameter int TIMEOUT = 256
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [N_REQ-1:0]     REQ,
    input  logic [16*N_REQ-1:0]  CODE,
    output logic [N_REQ-1:0]     ACK,
    output logic                 BUSY,
    output logic                 DAC_TR,
    output logic [23:0]          DAC_DATA,
    input  logic                 DAC_OVER,
    output logic [15:0]          LAST_CODE,
    output logic                 ERR
);

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CMAX = (TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(MIN_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_DONE   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [IW-1:0]     rr_ptr, rr_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [N_REQ-1:0]  ack_nxt;
    logic              busy_nxt;
    logic              tr_nxt;
    logic              err_nxt;
    logic [23:0]       data_nxt;
    logic [15:0]       last_nxt;
`ifdef SKIP_DUP_EN
    logic              have_frame, have_frame_nxt;
`endif

    // Requester index rr_ptr+k, wrapped at N_REQ (N_REQ need not be a power of two).
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur);
        return (cur == IDX_LAST) ? '0 : cur + 1'b1;
    endfunction

    // Round-robin selection: first set REQ scanning upward from rr_ptr.
    logic          sel_vld;
    logic [IW-1:0] sel_idx;
    logic [15:0]   sel_code;

    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        sel_code = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_vld && REQ[wrap_add(rr_ptr, k)]) begin
                sel_vld = 1'b1;
                sel_idx = wrap_add(rr_ptr, k);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == IW'(i)) sel_code = CODE[16*i +: 16];
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rr_nxt    = rr_ptr;
        cnt_nxt   = cnt;
        ack_nxt   = '0;
        busy_nxt  = BUSY;
        tr_nxt    = DAC_TR;
        err_nxt   = ERR;
        data_nxt  = DAC_DATA;
        last_nxt  = LAST_CODE;
`ifdef SKIP_DUP_EN
        have_frame_nxt = have_frame;
`endif
        unique case (state)
            S_IDLE: begin
                // DAC_OVER low here means the writer is still draining a frame.
                if (sel_vld && DAC_OVER) begin
`ifdef SKIP_DUP_EN
                    if (have_frame && (sel_code == LAST_CODE)) begin
                        // Writer already holds this code: acknowledge without a frame.
                        ack_nxt[sel_idx] = 1'b1;
                        rr_nxt           = next_idx(sel_idx);
                    end else
`endif
                    begin
                        idx_nxt   = sel_idx;
                        data_nxt  = {8'h00, sel_code};
                        busy_nxt  = 1'b1;
                        tr_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (!DAC_OVER) begin
                    tr_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end else if (cnt == TO_LAST) begin
                    // Writer never accepted: abort, keep rr_ptr so the same requester retries.
                    tr_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (DAC_OVER) begin
                    ack_nxt[idx] = 1'b1;
                    last_nxt     = DAC_DATA[15:0];
                    rr_nxt       = next_idx(idx);
                    cnt_nxt      = '0;
                    state_nxt    = S_HOLD;
`ifdef SKIP_DUP_EN
                    have_frame_nxt = 1'b1;
`endif
                end else if (cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == GAP_LAST) begin
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            idx       <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            ACK       <= '0;
            BUSY      <= 1'b0;
            DAC_TR    <= 1'b0;
            DAC_DATA  <= '0;
            LAST_CODE <= '0;
            ERR       <= 1'b0;
`ifdef SKIP_DUP_EN
            have_frame <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rr_ptr    <= rr_nxt;
            cnt       <= cnt_nxt;
            ACK       <= ack_nxt;
            BUSY      <= busy_nxt;
            DAC_TR    <= tr_nxt;
            DAC_DATA  <= data_nxt;
            LAST_CODE <= last_nxt;
            ERR       <= err_nxt;
`ifdef SKIP_DUP_EN
            have_frame <= have_frame_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_dac8531_update_arbiter.sv
// Purpose : directed self-checking bench for dac8531_update_arbiter with a DAC writer model.
// Latency : writer drops DAC_OVER on the first TR it sees and raises it 4 cycles later.
// Backpres: writer can be killed (never drops DAC_OVER) to force handshake timeouts.
module tb_dac8531_update_arbiter;

    localparam int N_REQ   = 4;
    localparam int MIN_GAP = 16;
    localparam int TIMEOUT = 256;

    logic                 CLK      = 1'b0;
    logic                 RESET_N  = 1'b0;
    logic [N_REQ-1:0]     REQ      = '0;
    logic [16*N_REQ-1:0]  CODE     = '0;
    logic [N_REQ-1:0]     ACK;
    logic                 BUSY;
    logic                 DAC_TR;
    logic [23:0]          DAC_DATA;
    logic                 DAC_OVER = 1'b1;
    logic [15:0]          LAST_CODE;
    logic                 ERR;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    dac8531_update_arbiter #(
        .N_REQ   (N_REQ),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .REQ       (REQ),
        .CODE      (CODE),
        .ACK       (ACK),
        .BUSY      (BUSY),
        .DAC_TR    (DAC_TR),
        .DAC_DATA  (DAC_DATA),
        .DAC_OVER  (DAC_OVER),
        .LAST_CODE (LAST_CODE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Writer model and event recorders, all on the falling edge.
    bit          writer_dead   = 1'b0;
    int          wr_cnt        = 0;
    int          frames        = 0;
    logic [23:0] frame_q[$];
    int          gap_q[$];
    int          ack_cnt[N_REQ];
    int          ack_multi     = 0;
    int          tr_cycles     = 0;
    int          over_rise_cyc = 0;

    always @(negedge CLK) begin
        if (DAC_TR) tr_cycles++;
        if ($countones(ACK) > 1) ack_multi++;
        for (int i = 0; i < N_REQ; i++) if (ACK[i]) ack_cnt[i]++;
        if (wr_cnt != 0) begin
            wr_cnt--;
            if (wr_cnt == 0) begin
                DAC_OVER      = 1'b1;
                over_rise_cyc = cyc;
            end
        end else if (DAC_TR && DAC_OVER && !writer_dead) begin
            DAC_OVER = 1'b0;
            wr_cnt   = 4;
            frames++;
            frame_q.push_back(DAC_DATA);
            gap_q.push_back(cyc - over_rise_cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        REQ     = '0;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        for (int i = 0; i < 20 && !DAC_OVER; i++) @(posedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input int bound, output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (ACK != '0) begin
                ok = 1'b1;
                for (int k = 0; k < N_REQ; k++) if (ACK[k]) idx = k;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (!BUSY) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (ACK !== '0 || BUSY !== 1'b0 || DAC_TR !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: ACK=%b BUSY=%b TR=%b, required all 0", ACK, BUSY, DAC_TR);
        end
        tests++;
        if (DAC_DATA !== 24'h0 || LAST_CODE !== 16'h0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: DATA=%h LAST=%h ERR=%b, required 0", DAC_DATA, LAST_CODE, ERR);
        end
    endtask

    task automatic test_single();
        int idx; bit ok; int f0; int a;
        do_reset();
        f0 = frames;
        CODE[15:0] = 16'h1234;
        REQ = 4'b0001;
        wait_ack(100, idx, ok);
        REQ = '0;
        a = cyc;
        tests++;
        if (!ok || idx != 0) begin
            fails++;
            $display("FAIL single_ack: ok=%0d idx=%0d, required ack on 0", ok, idx);
        end
        tests++;
        if (frames - f0 != 1) begin
            fails++;
            $display("FAIL single_frames: %0d frames, required 1", frames - f0);
        end
        tests++;
        if (DAC_DATA !== 24'h001234) begin
            fails++;
            $display("FAIL single_data: %h, required 001234", DAC_DATA);
        end
        tests++;
        if (LAST_CODE !== 16'h1234) begin
            fails++;
            $display("FAIL single_last: %h, required 1234", LAST_CODE);
        end
        tests++;
        if (a - over_rise_cyc != 1) begin
            fails++;
            $display("FAIL single_ack_lat: %0d cycles after OVER rise, required 1", a - over_rise_cyc);
        end
        repeat (15) @(posedge CLK);
        #1;
        tests++;
        if (BUSY !== 1'b1) begin
            fails++;
            $display("FAIL single_busy_gap: BUSY=%b 15 cycles after ACK, required 1", BUSY);
        end
        @(posedge CLK);
        #1;
        tests++;
        if (BUSY !== 1'b0) begin
            fails++;
            $display("FAIL single_busy_end: BUSY=%b 16 cycles after ACK, required 0", BUSY);
        end
    endtask

    task automatic test_round_robin();
        int idx; bit ok; int fq0; int g0;
        logic [15:0] exp_codes[5];
        exp_codes = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA000};
        do_reset();
        fq0  = frame_q.size();
        g0   = gap_q.size();
        CODE = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        REQ  = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack(200, idx, ok);
            tests++;
            if (!ok || idx != n % 4) begin
                fails++;
                $display("FAIL rr_order[%0d]: ok=%0d idx=%0d, required %0d", n, ok, idx, n % 4);
            end
        end
        REQ = '0;
        wait_idle(100, ok);
        tests++;
        if (frame_q.size() - fq0 != 5) begin
            fails++;
            $display("FAIL rr_frames: %0d frames, required 5", frame_q.size() - fq0);
        end else begin
            for (int n = 0; n < 5; n++) begin
                tests++;
                if (frame_q[fq0+n] !== {8'h00, exp_codes[n]}) begin
                    fails++;
                    $display("FAIL rr_data[%0d]: %h, required %h", n, frame_q[fq0+n], {8'h00, exp_codes[n]});
                end
            end
            for (int n = 1; n < 5; n++) begin
                tests++;
                if (gap_q[g0+n] < MIN_GAP) begin
                    fails++;
                    $display("FAIL rr_gap[%0d]: %0d idle cycles, required >= %0d", n, gap_q[g0+n], MIN_GAP);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int idx; bit ok; int t0; int a0; int asum;
        do_reset();
        t0 = tr_cycles;
        a0 = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
        writer_dead  = 1'b1;
        CODE[31:16]  = 16'h5555;
        CODE[47:32]  = 16'h6666;
        REQ          = 4'b0110;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (ERR) ok = 1'b1;
        end
        asum = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL to_err: ERR=%b after 400 cycles, required 1", ERR);
        end
        tests++;
        if (tr_cycles - t0 != TIMEOUT) begin
            fails++;
            $display("FAIL to_tr_len: TR high %0d cycles, required %0d", tr_cycles - t0, TIMEOUT);
        end
        tests++;
        if (asum != a0) begin
            fails++;
            $display("FAIL to_no_ack: %0d ACKs, required 0", asum - a0);
        end
        writer_dead = 1'b0;
        wait_ack(200, idx, ok);
        REQ = '0;
        tests++;
        if (!ok || idx != 1) begin
            fails++;
            $display("FAIL to_retry: ok=%0d idx=%0d, required retry on 1", ok, idx);
        end
        tests++;
        if (LAST_CODE !== 16'h5555) begin
            fails++;
            $display("FAIL to_retry_last: %h, required 5555", LAST_CODE);
        end
        tests++;
        if (ERR !== 1'b1) begin
            fails++;
            $display("FAIL to_err_sticky: ERR=%b after success, required 1", ERR);
        end
        wait_idle(100, ok);
    endtask

    // Runs straight after test_timeout: ERR=1, LAST_CODE=5555, rr pointer at 2.
    task automatic test_reset_mid_done();
        int idx; bit ok;
        CODE[15:0]  = 16'h0A0A;
        CODE[31:16] = 16'h1B1B;
        CODE[63:48] = 16'h3B3B;
        REQ = 4'b1011;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (!DAC_OVER) ok = 1'b1;
        end
        tests++;
        if (!ok || DAC_DATA !== 24'h003B3B) begin
            fails++;
            $display("FAIL rst_pre_pick: ok=%0d DATA=%h, required 003B3B", ok, DAC_DATA);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        tests++;
        if (BUSY !== 1'b0 || DAC_TR !== 1'b0 || ACK !== '0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_ctrl: BUSY=%b TR=%b ACK=%b ERR=%b, required 0", BUSY, DAC_TR, ACK, ERR);
        end
        tests++;
        if (DAC_DATA !== 24'h0 || LAST_CODE !== 16'h0) begin
            fails++;
            $display("FAIL rst_mid_data: DATA=%h LAST=%h, required 0", DAC_DATA, LAST_CODE);
        end
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        wait_ack(100, idx, ok);
        REQ = '0;
        tests++;
        if (!ok || idx != 0 || LAST_CODE !== 16'h0A0A) begin
            fails++;
            $display("FAIL rst_post_serve: ok=%0d idx=%0d LAST=%h, required 0 / 0A0A", ok, idx, LAST_CODE);
        end
        wait_idle(100, ok);
    endtask

    task automatic test_dup_code();
        int idx; bit ok; int f0; int f1; int exp_frames;
`ifdef SKIP_DUP_EN
        exp_frames = 0;
`else
        exp_frames = 1;
`endif
        do_reset();
        CODE[15:0] = 16'h00FF;
        REQ = 4'b0001;
        wait_ack(100, idx, ok);
        REQ = '0;
        wait_idle(100, ok);
        f0 = frames;
        REQ = 4'b0001;
        wait_ack(100, idx, ok);
        REQ = '0;
        tests++;
        if (!ok || idx != 0) begin
            fails++;
            $display("FAIL dup_ack: ok=%0d idx=%0d, required ack on 0", ok, idx);
        end
        tests++;
        if (frames - f0 != exp_frames) begin
            fails++;
            $display("FAIL dup_frames: %0d frames for repeated code, required %0d", frames - f0, exp_frames);
        end
        wait_idle(100, ok);
        f1 = frames;
        CODE[15:0] = 16'h0100;
        REQ = 4'b0001;
        wait_ack(100, idx, ok);
        REQ = '0;
        tests++;
        if (!ok || frames - f1 != 1 || LAST_CODE !== 16'h0100) begin
            fails++;
            $display("FAIL dup_new_code: ok=%0d frames=%0d LAST=%h, required 1 frame / 0100", ok, frames - f1, LAST_CODE);
        end
        wait_idle(100, ok);
    endtask

    task automatic test_withdrawn_pulse();
        int idx; bit ok; int c2; int f0;
        do_reset();
        c2 = ack_cnt[2];
        f0 = frames;
        CODE[15:0]  = 16'h1111;
        CODE[47:32] = 16'h2222;
        REQ = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (BUSY) ok = 1'b1;
        end
        REQ[2] = 1'b1;
        @(posedge CLK);
        #1;
        REQ[2] = 1'b0;
        wait_ack(100, idx, ok);
        REQ = '0;
        tests++;
        if (!ok || idx != 0) begin
            fails++;
            $display("FAIL pulse_ack0: ok=%0d idx=%0d, required ack on 0", ok, idx);
        end
        wait_idle(100, ok);
        repeat (40) @(posedge CLK);
        #1;
        tests++;
        if (ack_cnt[2] != c2 || frames - f0 != 1) begin
            fails++;
            $display("FAIL pulse_ignored: ACK[2] count %0d frames %0d, required 0 / 1", ack_cnt[2] - c2, frames - f0);
        end
        tests++;
        if (ack_multi != 0) begin
            fails++;
            $display("FAIL ack_onehot: %0d cycles with multiple ACK bits, required 0", ack_multi);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_done();
        test_dup_code();
        test_withdrawn_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
